// File: rtl/oddr_clock_divider_gen_if.sv
// Bundle of control and DDR-slot signals for the forwarded-clock generator.
//   en_i           run request, level-sensitive
//   half_period_i  requested H (clk_i cycles per output period)
//   d_rise_o       DDR bit for the first half of the current cycle
//   d_fall_o       DDR bit for the second half of the current cycle
//   period_start_o high in the cycle whose rise slot is the rising edge
//   active_o       a period is in progress
//   hp_o           H currently in effect
// master: drives the controls (user logic / bench); slave: the generator.
interface oddr_clock_divider_gen_if #(
    parameter int unsigned hp_width_p = 8
) ();
    logic                  en_i;
    logic [hp_width_p-1:0] half_period_i;
    logic                  d_rise_o;
    logic                  d_fall_o;
    logic                  period_start_o;
    logic                  active_o;
    logic [hp_width_p-1:0] hp_o;

    modport master (
        output en_i, half_period_i,
        input  d_rise_o, d_fall_o, period_start_o, active_o, hp_o
    );

    modport slave (
        input  en_i, half_period_i,
        output d_rise_o, d_fall_o, period_start_o, active_o, hp_o
    );
endinterface

// File: rtl/oddr_clock_divider_gen.sv
// Programmable forwarded-clock generator. Each clk_i cycle emits a rise/fall
// slot pair for an external DDR output cell, so the forwarded clock has
// half-cycle duty resolution. The divide ratio is sampled only at period
// boundaries, so ratio changes and stop requests never cut a period short.
// Ports:
//   clk_i      sole clock, all logic on posedge
//   reset_n_i  asynchronous active-low reset
//   bus        oddr_clock_divider_gen_if slave modport (controls + DDR slots)
module oddr_clock_divider_gen #(
    parameter int unsigned hp_width_p = 8,
    parameter int unsigned reset_hp_p = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    oddr_clock_divider_gen_if.slave  bus
);
    // One extra bit so 2H and cnt+1 never overflow at H = 2^w-1.
    localparam int unsigned CntW = hp_width_p + 1;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [hp_width_p-1:0] hp_q, hp_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  start_q, start_d;
    logic                  active_q, active_d;

    logic [CntW-1:0] cnt_next;
    logic [CntW-1:0] hp_ext;
    logic [CntW-1:0] two_h;
    logic            run_ok;

    assign cnt_next = cnt_q + CntW'(2);
    assign hp_ext   = {1'b0, hp_q};
    assign two_h    = {hp_q, 1'b0};
    assign run_ok   = bus.en_i && (bus.half_period_i != '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hp_d     = hp_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        start_d  = 1'b0;
        active_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run_ok) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    hp_d    = bus.half_period_i;
                end
            end
            StRun: begin
                // cnt counts half-cycle slots; cnt is the rise slot, cnt+1 the fall slot.
                rise_d   = cnt_q < hp_ext;
                fall_d   = (cnt_q + CntW'(1)) < hp_ext;
                start_d  = (cnt_q == '0);
                active_d = 1'b1;
                if (cnt_next == two_h) begin
                    cnt_d = '0;
                    if (run_ok) begin
                        hp_d = bus.half_period_i;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_next;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hp_q     <= hp_width_p'(reset_hp_p);
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hp_q     <= hp_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            start_q  <= start_d;
            active_q <= active_d;
        end
    end

    assign bus.d_rise_o       = rise_q;
    assign bus.d_fall_o       = fall_q;
    assign bus.period_start_o = start_q;
    assign bus.active_o       = active_q;
    assign bus.hp_o           = hp_q;
endmodule
